// File: rtl/fp_result_collector_if.sv
// Return-path bundle between the execution units, the collector and the CPU.
// Sticky-overflow signals exist only when OVF_STICKY_EN is defined.
interface fp_result_collector_if;
   logic [31:0] add_result;
   logic        add_done;
   logic        add_overflow;
   logic [31:0] mul_result;
   logic        mul_done;
   logic        mul_overflow;
   logic [31:0] sine_result;
   logic [31:0] cosine_result;
   logic        sine_done;
   logic        cpu_ack;
   logic [31:0] result;
   logic        overflow;
   logic [1:0]  result_tag;
   logic        done;
   logic        out_fifo_hold;
   logic        collision_err;
`ifdef OVF_STICKY_EN
   logic        clr_sticky;
   logic        overflow_sticky;
`endif

   modport slave (
      input  add_result, add_done, add_overflow,
      input  mul_result, mul_done, mul_overflow,
      input  sine_result, cosine_result, sine_done,
      input  cpu_ack,
`ifdef OVF_STICKY_EN
      input  clr_sticky,
      output overflow_sticky,
`endif
      output result, overflow, result_tag, done, out_fifo_hold, collision_err
   );

   modport master (
      output add_result, add_done, add_overflow,
      output mul_result, mul_done, mul_overflow,
      output sine_result, cosine_result, sine_done,
      output cpu_ack,
`ifdef OVF_STICKY_EN
      output clr_sticky,
      input  overflow_sticky,
`endif
      input  result, overflow, result_tag, done, out_fifo_hold, collision_err
   );
endinterface

// File: rtl/fp_result_collector.sv
// Captures add/mul/sincos completions into pending slots and serialises them, source-tagged,
// into a show-ahead output FIFO. Optional sticky overflow flag under OVF_STICKY_EN.
module fp_result_collector #(
   parameter int DEPTH       = 8,
   parameter int HOLD_THRESH = 2
) (
   input logic                  clk,
   input logic                  n_rst,
   fp_result_collector_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic [31:0] data;
      logic        ovf;
      logic [1:0]  tag;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d, remain;
   entry_t        head_q, head_d;
   logic          done_q, done_d, hold_q, hold_d, coll_q, coll_d;

   logic          addOcc_q, addOcc_d, mulOcc_q, mulOcc_d;
   entry_t        addSlot_q, addSlot_d, mulSlot_q, mulSlot_d;
   logic          sinOcc_q, sinOcc_d, sinSent_q, sinSent_d;
   logic [31:0]   sinData_q, sinData_d, cosData_q, cosData_d;

   logic          pop, canPush, push, addPush, mulPush, sinPush, cosPush;
   entry_t        pushEntry;
   logic [2:0]    pendWords;

   always_comb begin
      pop       = bus.cpu_ack && done_q;
      canPush   = (count_q != FULL_CNT) || pop;
      addPush   = 1'b0;
      mulPush   = 1'b0;
      sinPush   = 1'b0;
      cosPush   = 1'b0;
      pushEntry = '0;
      if (canPush) begin
         if (addOcc_q)      addPush = 1'b1;
         else if (mulOcc_q) mulPush = 1'b1;
         else if (sinOcc_q) begin
            if (sinSent_q) cosPush = 1'b1;
            else           sinPush = 1'b1;
         end
      end
      push = addPush || mulPush || sinPush || cosPush;
      if (addPush)      pushEntry = addSlot_q;
      else if (mulPush) pushEntry = mulSlot_q;
      else if (sinPush) pushEntry = '{data: sinData_q, ovf: 1'b0, tag: 2'b10};
      else if (cosPush) pushEntry = '{data: cosData_q, ovf: 1'b0, tag: 2'b11};

      // A slot drained at this edge may take a new capture at the same edge.
      coll_d    = 1'b0;
      addOcc_d  = addOcc_q && !addPush;
      addSlot_d = addSlot_q;
      if (bus.add_done) begin
         if (!addOcc_d) begin
            addOcc_d  = 1'b1;
            addSlot_d = '{data: bus.add_result, ovf: bus.add_overflow, tag: 2'b00};
         end else begin
            coll_d = 1'b1;
         end
      end
      mulOcc_d  = mulOcc_q && !mulPush;
      mulSlot_d = mulSlot_q;
      if (bus.mul_done) begin
         if (!mulOcc_d) begin
            mulOcc_d  = 1'b1;
            mulSlot_d = '{data: bus.mul_result, ovf: bus.mul_overflow, tag: 2'b01};
         end else begin
            coll_d = 1'b1;
         end
      end
      sinOcc_d  = sinOcc_q && !cosPush;
      sinSent_d = sinPush ? 1'b1 : (cosPush ? 1'b0 : sinSent_q);
      sinData_d = sinData_q;
      cosData_d = cosData_q;
      if (bus.sine_done) begin
         if (!sinOcc_d) begin
            sinOcc_d  = 1'b1;
            sinSent_d = 1'b0;
            sinData_d = bus.sine_result;
            cosData_d = bus.cosine_result;
         end else begin
            coll_d = 1'b1;
         end
      end

      wrPtr_d = wrPtr_q + PW'(push);
      rdPtr_d = rdPtr_q + PW'(pop);
      count_d = count_q + CW'(push) - CW'(pop);
      remain  = count_q - CW'(pop);
      done_d  = (count_d != '0);
      // The new head is the word being written when the FIFO would otherwise be empty.
      if (count_d == '0)     head_d = '0;
      else if (remain == '0) head_d = pushEntry;
      else                   head_d = mem_q[rdPtr_d];

      pendWords = {2'b00, addOcc_d} + {2'b00, mulOcc_d}
                + (sinOcc_d ? (sinSent_d ? 3'd1 : 3'd2) : 3'd0);
      hold_d    = (int'(count_d) + int'(pendWords) + HOLD_THRESH) >= DEPTH;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q] <= pushEntry;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         head_q    <= '0;
         done_q    <= 1'b0;
         hold_q    <= 1'b0;
         coll_q    <= 1'b0;
         addOcc_q  <= 1'b0;
         addSlot_q <= '0;
         mulOcc_q  <= 1'b0;
         mulSlot_q <= '0;
         sinOcc_q  <= 1'b0;
         sinSent_q <= 1'b0;
         sinData_q <= '0;
         cosData_q <= '0;
      end else begin
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         count_q   <= count_d;
         head_q    <= head_d;
         done_q    <= done_d;
         hold_q    <= hold_d;
         coll_q    <= coll_d;
         addOcc_q  <= addOcc_d;
         addSlot_q <= addSlot_d;
         mulOcc_q  <= mulOcc_d;
         mulSlot_q <= mulSlot_d;
         sinOcc_q  <= sinOcc_d;
         sinSent_q <= sinSent_d;
         sinData_q <= sinData_d;
         cosData_q <= cosData_d;
      end
   end

   assign bus.result        = head_q.data;
   assign bus.overflow      = head_q.ovf;
   assign bus.result_tag    = head_q.tag;
   assign bus.done          = done_q;
   assign bus.out_fifo_hold = hold_q;
   assign bus.collision_err = coll_q;

`ifdef OVF_STICKY_EN
   logic sticky_q, sticky_d;

   // Setting on an overflow pop takes precedence over a simultaneous clear.
   always_comb begin
      sticky_d = sticky_q;
      if (pop && head_q.ovf)   sticky_d = 1'b1;
      else if (bus.clr_sticky) sticky_d = 1'b0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) sticky_q <= 1'b0;
      else        sticky_q <= sticky_d;
   end

   assign bus.overflow_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_fp_result_collector.sv
// Randomised and directed bench for fp_result_collector against a queue-based model of
// pending slots and the output FIFO; build with OVF_STICKY_EN to cover the sticky flag.
module tb_fp_result_collector;
   localparam int DEPTH       = 8;
   localparam int HOLD_THRESH = 2;

   typedef struct packed {
      logic [31:0] data;
      logic        ovf;
      logic [1:0]  tag;
   } tbEnt_t;

   logic clk;
   logic n_rst;
   logic clrSticky;
   int   testCount = 0;
   int   failCount = 0;

   fp_result_collector_if bus();

   fp_result_collector #(.DEPTH(DEPTH), .HOLD_THRESH(HOLD_THRESH)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

`ifdef OVF_STICKY_EN
   assign bus.clr_sticky = clrSticky;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   tbEnt_t fifoQ[$];
   tbEnt_t addQ[$];
   tbEnt_t mulQ[$];
   tbEnt_t sinQ[$];
   bit     expColl   = 1'b0;
   bit     expHold   = 1'b0;
   bit     expSticky = 1'b0;

   function automatic tbEnt_t mkEnt(input logic [31:0] d, input logic o, input logic [1:0] t);
      tbEnt_t e;
      e.data = d;
      e.ovf  = o;
      e.tag  = t;
      return e;
   endfunction

   // Model: each unit owns a queue of words still to be pushed; the FIFO is a plain queue.
   always @(posedge clk or negedge n_rst) begin
      bit     doPop, room, havePush, stickySet;
      tbEnt_t pushE, popped;
      int     freeSlots;
      if (!n_rst) begin
         fifoQ.delete();
         addQ.delete();
         mulQ.delete();
         sinQ.delete();
         expColl   = 1'b0;
         expHold   = 1'b0;
         expSticky = 1'b0;
      end else begin
         doPop     = bus.cpu_ack && (fifoQ.size() != 0);
         room      = (fifoQ.size() < DEPTH) || doPop;
         havePush  = 1'b0;
         stickySet = 1'b0;
         pushE     = '0;
         if (room) begin
            if (addQ.size() != 0)      begin pushE = addQ.pop_front(); havePush = 1'b1; end
            else if (mulQ.size() != 0) begin pushE = mulQ.pop_front(); havePush = 1'b1; end
            else if (sinQ.size() != 0) begin pushE = sinQ.pop_front(); havePush = 1'b1; end
         end
         if (doPop) begin
            popped = fifoQ.pop_front();
            stickySet = popped.ovf;
         end
         if (havePush) fifoQ.push_back(pushE);
         expColl = 1'b0;
         if (bus.add_done) begin
            if (addQ.size() == 0) addQ.push_back(mkEnt(bus.add_result, bus.add_overflow, 2'b00));
            else expColl = 1'b1;
         end
         if (bus.mul_done) begin
            if (mulQ.size() == 0) mulQ.push_back(mkEnt(bus.mul_result, bus.mul_overflow, 2'b01));
            else expColl = 1'b1;
         end
         if (bus.sine_done) begin
            if (sinQ.size() == 0) begin
               sinQ.push_back(mkEnt(bus.sine_result, 1'b0, 2'b10));
               sinQ.push_back(mkEnt(bus.cosine_result, 1'b0, 2'b11));
            end else begin
               expColl = 1'b1;
            end
         end
         if (stickySet)      expSticky = 1'b1;
         else if (clrSticky) expSticky = 1'b0;
         freeSlots = DEPTH - fifoQ.size() - addQ.size() - mulQ.size() - sinQ.size();
         expHold   = freeSlots <= HOLD_THRESH;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, compare the registered outputs against the model state after the edge.
   always @(posedge clk) begin
      #2;
      checkOutput("done", 32'(bus.done), 32'(fifoQ.size() != 0));
      if (fifoQ.size() != 0) begin
         checkOutput("result", bus.result, fifoQ[0].data);
         checkOutput("overflow", 32'(bus.overflow), 32'(fifoQ[0].ovf));
         checkOutput("tag", 32'(bus.result_tag), 32'(fifoQ[0].tag));
      end
      checkOutput("hold", 32'(bus.out_fifo_hold), 32'(expHold));
      checkOutput("collision", 32'(bus.collision_err), 32'(expColl));
`ifdef OVF_STICKY_EN
      checkOutput("sticky", 32'(bus.overflow_sticky), 32'(expSticky));
`endif
   end

   task automatic clearInputs();
      bus.add_done      = 1'b0;
      bus.mul_done      = 1'b0;
      bus.sine_done     = 1'b0;
      bus.cpu_ack       = 1'b0;
      bus.add_result    = '0;
      bus.mul_result    = '0;
      bus.sine_result   = '0;
      bus.cosine_result = '0;
      bus.add_overflow  = 1'b0;
      bus.mul_overflow  = 1'b0;
      clrSticky         = 1'b0;
   endtask

   // One cycle: unit data is derived from d (add=d, mul=d^1, sin=d^2, cos=d^3).
   task automatic applyStimulus(input bit a, input bit m, input bit s, input bit ack,
                                input bit clr, input logic [31:0] d);
      @(negedge clk);
      bus.add_done      = a;
      bus.mul_done      = m;
      bus.sine_done     = s;
      bus.cpu_ack       = ack;
      clrSticky         = clr;
      bus.add_result    = d;
      bus.mul_result    = d ^ 32'h1;
      bus.sine_result   = d ^ 32'h2;
      bus.cosine_result = d ^ 32'h3;
      bus.add_overflow  = d[0];
      bus.mul_overflow  = d[1];
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic resetDut();
      @(negedge clk);
      clearInputs();
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   initial begin
      clearInputs();
      n_rst = 1'b1;
      #1 n_rst = 1'b0;
      #1;
      checkOutput("rst_done", 32'(bus.done), 32'h0);
      checkOutput("rst_result", bus.result, 32'h0);
      checkOutput("rst_tag", 32'(bus.result_tag), 32'h0);
      checkOutput("rst_hold", 32'(bus.out_fifo_hold), 32'h0);
      checkOutput("rst_coll", 32'(bus.collision_err), 32'h0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;

      // Single add: visible one edge after capture, cleared by ack.
      applyStimulus(1, 0, 0, 0, 0, 32'h40400000);
      checkOutput("t1_done_early", 32'(bus.done), 32'h0);
      idle(1);
      checkOutput("t1_done", 32'(bus.done), 32'h1);
      checkOutput("t1_result", bus.result, 32'h40400000);
      checkOutput("t1_tag", 32'(bus.result_tag), 32'h0);
      applyStimulus(0, 0, 0, 1, 0, 32'h0);
      checkOutput("t1_done_ack", 32'(bus.done), 32'h0);

      // Simultaneous completions drain in add, mul, sin, cos order.
      applyStimulus(1, 1, 1, 0, 0, 32'h10000000);
      checkOutput("t2_coll", 32'(bus.collision_err), 32'h0);
      idle(4);
      checkOutput("t2_head0", bus.result, 32'h10000000);
      checkOutput("t2_tag0", 32'(bus.result_tag), 32'h0);
      applyStimulus(0, 0, 0, 1, 0, 32'h0);
      checkOutput("t2_head1", bus.result, 32'h10000001);
      checkOutput("t2_tag1", 32'(bus.result_tag), 32'h1);
      applyStimulus(0, 0, 0, 1, 0, 32'h0);
      checkOutput("t2_head2", bus.result, 32'h10000002);
      checkOutput("t2_tag2", 32'(bus.result_tag), 32'h2);
      applyStimulus(0, 0, 0, 1, 0, 32'h0);
      checkOutput("t2_head3", bus.result, 32'h10000003);
      checkOutput("t2_tag3", 32'(bus.result_tag), 32'h3);
      applyStimulus(0, 0, 0, 1, 0, 32'h0);
      checkOutput("t2_empty", 32'(bus.done), 32'h0);

      // Fill to full, hold threshold, pending mul, collision, push-on-pop.
      resetDut();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 32'h100 + 32'(i));
         if (i == 4) checkOutput("t3_hold_off", 32'(bus.out_fifo_hold), 32'h0);
         if (i == 5) checkOutput("t3_hold_on", 32'(bus.out_fifo_hold), 32'h1);
      end
      applyStimulus(0, 1, 0, 0, 0, 32'hA0);
      checkOutput("t3_coll_first", 32'(bus.collision_err), 32'h0);
      applyStimulus(0, 1, 0, 0, 0, 32'hB0);
      checkOutput("t3_coll", 32'(bus.collision_err), 32'h1);
      idle(1);
      checkOutput("t3_coll_pulse", 32'(bus.collision_err), 32'h0);
      checkOutput("t3_full_hold", 32'(bus.out_fifo_hold), 32'h1);
      applyStimulus(0, 0, 0, 1, 0, 32'h0);
      checkOutput("t3_head_after_pop", bus.result, 32'h101);
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0, 32'h0);
      checkOutput("t3_mul_result", bus.result, 32'hA1);
      checkOutput("t3_mul_tag", 32'(bus.result_tag), 32'h1);
      applyStimulus(0, 0, 0, 1, 0, 32'h0);
      checkOutput("t3_drained", 32'(bus.done), 32'h0);

      // Overflow flag on the head, and sticky set/clear priority.
      resetDut();
      applyStimulus(0, 1, 0, 0, 0, 32'h2);
      idle(1);
      checkOutput("t5_ovf", 32'(bus.overflow), 32'h1);
      applyStimulus(0, 0, 0, 1, 0, 32'h0);
`ifdef OVF_STICKY_EN
      checkOutput("t5_sticky_set", 32'(bus.overflow_sticky), 32'h1);
      applyStimulus(0, 0, 0, 0, 1, 32'h0);
      checkOutput("t5_sticky_clr", 32'(bus.overflow_sticky), 32'h0);
      applyStimulus(0, 1, 0, 0, 0, 32'h2);
      idle(1);
      applyStimulus(0, 0, 0, 1, 1, 32'h0);
      checkOutput("t5_sticky_win", 32'(bus.overflow_sticky), 32'h1);
`endif

      // Asynchronous reset with three entries queued and cos still pending.
      resetDut();
      applyStimulus(1, 1, 1, 0, 0, 32'h20000000);
      idle(3);
      checkOutput("t6_pre_done", 32'(bus.done), 32'h1);
      #2 n_rst = 1'b0;
      #1;
      checkOutput("t6_done", 32'(bus.done), 32'h0);
      checkOutput("t6_result", bus.result, 32'h0);
      checkOutput("t6_tag", 32'(bus.result_tag), 32'h0);
      checkOutput("t6_hold", 32'(bus.out_fifo_hold), 32'h0);
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         checkOutput("t6_no_stale", 32'(bus.done), 32'h0);
      end

      // Random traffic: a congested phase, then a draining phase.
      resetDut();
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3) == 0,
                       (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                       $urandom_range(0, 7) == 0, $urandom);
      end
      idle(20);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule
